// File: rtl/ft_write_checker_if.sv
// Bus bundle between both zeroriscy data ports and the lockstep checker.
// master: drives core store traffic, enable/clear; observes flags/counters.
// slave : the checker; samples core traffic, drives flags/counters/state.
interface ft_write_checker_if #(
  parameter int CNT_W = 16
);
  logic             enable_i;
  logic             clear_i;
  logic             c1_req_i;
  logic             c1_gnt_i;
  logic             c1_we_i;
  logic [3:0]       c1_be_i;
  logic [31:0]      c1_addr_i;
  logic [31:0]      c1_wdata_i;
  logic             c2_req_i;
  logic             c2_gnt_i;
  logic             c2_we_i;
  logic [3:0]       c2_be_i;
  logic [31:0]      c2_addr_i;
  logic [31:0]      c2_wdata_i;
  logic             mismatch_o;
  logic             overflow_o;
  logic             fault_irq_o;
  logic [31:0]      mm_addr_o;
  logic [CNT_W-1:0] mismatch_cnt_o;
  logic [31:0]      compare_cnt_o;
  logic [1:0]       state_o;

  modport master (
    output enable_i, clear_i,
    output c1_req_i, c1_gnt_i, c1_we_i,
    output c1_be_i, c1_addr_i, c1_wdata_i,
    output c2_req_i, c2_gnt_i, c2_we_i,
    output c2_be_i, c2_addr_i, c2_wdata_i,
    input  mismatch_o, overflow_o, fault_irq_o,
    input  mm_addr_o, mismatch_cnt_o,
    input  compare_cnt_o, state_o
  );

  modport slave (
    input  enable_i, clear_i,
    input  c1_req_i, c1_gnt_i, c1_we_i,
    input  c1_be_i, c1_addr_i, c1_wdata_i,
    input  c2_req_i, c2_gnt_i, c2_we_i,
    input  c2_be_i, c2_addr_i, c2_wdata_i,
    output mismatch_o, overflow_o, fault_irq_o,
    output mm_addr_o, mismatch_cnt_o,
    output compare_cnt_o, state_o
  );
endinterface

// File: rtl/ft_write_checker.sv
// Lockstep store checker: queues granted stores of two cores per core,
// compares the queue heads in order and flags the first divergence.
// Ports: clk_i, rst_i (async, active-high), bus (slave side of
// ft_write_checker_if: core store buses, enable/clear, flags, counters).
module ft_write_checker #(
  parameter int DEPTH      = 4,
  parameter int CNT_W      = 16,
  parameter bit HALT_ON_MM = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  ft_write_checker_if.slave bus
);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_CHECK = 2'b01,
    S_FAULT = 2'b10
  } state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } st_t;

  state_e           state_q, state_d;
  st_t              mem_q [2][DEPTH];
  st_t              mem_d [2][DEPTH];
  logic [PW-1:0]    wp_q [2];
  logic [PW-1:0]    wp_d [2];
  logic [PW-1:0]    rp_q [2];
  logic [PW-1:0]    rp_d [2];
  logic [PW:0]      cnt_q [2];
  logic [PW:0]      cnt_d [2];
  logic             cmp_vld_q, cmp_vld_d;
  logic             cmp_mm_q, cmp_mm_d;
  logic [31:0]      cmp_addr_q, cmp_addr_d;
  logic             mismatch_q, mismatch_d;
  logic             overflow_q, overflow_d;
  logic             irq_q, irq_d;
  logic [31:0]      mm_addr_q, mm_addr_d;
  logic [31:0]      cmp_cnt_q, cmp_cnt_d;
  logic [CNT_W-1:0] mm_cnt_q, mm_cnt_d;

  st_t  in_rec [2];
  st_t  head [2];
  logic push [2];
  logic full [2];
  logic wr [2];
  logic halt, can_pop, pop, ovf_ev, mm_ev;

  // Disabled byte lanes are zeroed so garbage there never miscompares.
  function automatic logic [31:0] mask_data(
    input logic [31:0] d,
    input logic [3:0]  be
  );
    logic [31:0] r;
    r = '0;
    for (int b = 0; b < 4; b++) begin
      r[8*b +: 8] = be[b] ? d[8*b +: 8] : 8'h00;
    end
    return r;
  endfunction

  always_comb begin
    in_rec[0] = {bus.c1_addr_i, bus.c1_be_i,
                 mask_data(bus.c1_wdata_i, bus.c1_be_i)};
    in_rec[1] = {bus.c2_addr_i, bus.c2_be_i,
                 mask_data(bus.c2_wdata_i, bus.c2_be_i)};

    halt = HALT_ON_MM && (state_q == S_FAULT);
    push[0] = bus.c1_req_i & bus.c1_gnt_i & bus.c1_we_i
            & bus.enable_i & ~halt;
    push[1] = bus.c2_req_i & bus.c2_gnt_i & bus.c2_we_i
            & bus.enable_i & ~halt;

    can_pop = (state_q == S_CHECK)
           || (state_q == S_FAULT && !HALT_ON_MM);
    pop = can_pop && (cnt_q[0] != '0) && (cnt_q[1] != '0);

    ovf_ev = 1'b0;
    mem_d  = mem_q;
    for (int i = 0; i < 2; i++) begin
      head[i] = mem_q[i][rp_q[i]];
      full[i] = (cnt_q[i] == (PW+1)'(DEPTH));
      // A full FIFO still accepts a push when its head leaves this cycle.
      wr[i]   = push[i] && (!full[i] || pop);
      ovf_ev  = ovf_ev | (push[i] && full[i] && !pop);
      wp_d[i] = wr[i] ? wp_q[i] + PW'(1) : wp_q[i];
      rp_d[i] = pop ? rp_q[i] + PW'(1) : rp_q[i];
      cnt_d[i] = cnt_q[i] + (PW+1)'(wr[i]) - (PW+1)'(pop);
      if (wr[i]) begin
        mem_d[i][wp_q[i]] = in_rec[i];
      end
    end

    cmp_vld_d  = pop;
    cmp_mm_d   = pop && (head[0] != head[1]);
    cmp_addr_d = head[0].addr;

    mm_ev      = cmp_vld_q && cmp_mm_q;
    cmp_cnt_d  = cmp_cnt_q + 32'(cmp_vld_q);
    mm_cnt_d   = mm_cnt_q;
    if (mm_ev && (mm_cnt_q != '1)) begin
      mm_cnt_d = mm_cnt_q + CNT_W'(1);
    end
    mismatch_d = mismatch_q | mm_ev;
    mm_addr_d  = (mm_ev && !mismatch_q) ? cmp_addr_q : mm_addr_q;
    overflow_d = overflow_q | ovf_ev;

    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.enable_i) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (mm_ev || ovf_ev) begin
          state_d = S_FAULT;
        end else if (!bus.enable_i && cnt_q[0] == '0
                     && cnt_q[1] == '0 && !cmp_vld_q) begin
          // Leave only once queued entries and the last
          // in-flight compare have drained.
          state_d = S_IDLE;
        end
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
    irq_d = (state_q == S_CHECK) && (state_d == S_FAULT);

    if (bus.clear_i) begin
      for (int i = 0; i < 2; i++) begin
        wp_d[i]  = '0;
        rp_d[i]  = '0;
        cnt_d[i] = '0;
      end
      cmp_vld_d  = 1'b0;
      cmp_mm_d   = 1'b0;
      cmp_addr_d = '0;
      cmp_cnt_d  = '0;
      mm_cnt_d   = '0;
      mismatch_d = 1'b0;
      mm_addr_d  = '0;
      overflow_d = 1'b0;
      state_d    = S_IDLE;
      irq_d      = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 2; i++) begin
        wp_q[i]  <= '0;
        rp_q[i]  <= '0;
        cnt_q[i] <= '0;
      end
      state_q    <= S_IDLE;
      cmp_vld_q  <= 1'b0;
      cmp_mm_q   <= 1'b0;
      cmp_addr_q <= '0;
      cmp_cnt_q  <= '0;
      mm_cnt_q   <= '0;
      mismatch_q <= 1'b0;
      mm_addr_q  <= '0;
      overflow_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        wp_q[i]  <= wp_d[i];
        rp_q[i]  <= rp_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      state_q    <= state_d;
      cmp_vld_q  <= cmp_vld_d;
      cmp_mm_q   <= cmp_mm_d;
      cmp_addr_q <= cmp_addr_d;
      cmp_cnt_q  <= cmp_cnt_d;
      mm_cnt_q   <= mm_cnt_d;
      mismatch_q <= mismatch_d;
      mm_addr_q  <= mm_addr_d;
      overflow_q <= overflow_d;
      irq_q      <= irq_d;
    end
  end

  // Storage needs no reset: pointers and counts define what is valid.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign bus.mismatch_o     = mismatch_q;
  assign bus.overflow_o     = overflow_q;
  assign bus.fault_irq_o    = irq_q;
  assign bus.mm_addr_o      = mm_addr_q;
  assign bus.mismatch_cnt_o = mm_cnt_q;
  assign bus.compare_cnt_o  = cmp_cnt_q;
  assign bus.state_o        = state_q;
endmodule

// File: tb/tb_ft_write_checker.sv
// Scoreboard bench for ft_write_checker: directed lockstep cases plus
// randomized per-core store schedules checked against a pairing model.
module tb_ft_write_checker;
  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } st_t;

  typedef struct {
    bit          mm;
    logic [31:0] addr;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ft_write_checker_if #(.CNT_W(16)) bus();

  ft_write_checker #(
    .DEPTH(4),
    .CNT_W(16),
    .HALT_ON_MM(1'b1)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus.slave)
  );

  int   checks  = 0;
  int   errors  = 0;
  int   irq_cnt = 0;
  exp_t exp_q[$];
  st_t  s1 [4];
  st_t  s2 [4];
  int   t1 [4];
  int   t2 [4];
  int   n;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h",
               name, act, exp);
    end
  endtask

  // Reference rule: two stores agree when address and byte enables
  // agree and every enabled byte carries the same value.
  function automatic bit same_store(input st_t a, input st_t b);
    if (a.addr != b.addr || a.be != b.be) return 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (a.be[k] && a.data[8*k +: 8] != b.data[8*k +: 8])
        return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic push_exp(input st_t a, input st_t b);
    exp_t e;
    e.mm   = !same_store(a, b);
    e.addr = a.addr;
    exp_q.push_back(e);
  endtask

  task automatic drv(input int core, input logic req,
                     input logic gnt, input logic we,
                     input st_t r);
    if (core == 1) begin
      bus.c1_req_i   = req;
      bus.c1_gnt_i   = gnt;
      bus.c1_we_i    = we;
      bus.c1_be_i    = r.be;
      bus.c1_addr_i  = r.addr;
      bus.c1_wdata_i = r.data;
    end else begin
      bus.c2_req_i   = req;
      bus.c2_gnt_i   = gnt;
      bus.c2_we_i    = we;
      bus.c2_be_i    = r.be;
      bus.c2_addr_i  = r.addr;
      bus.c2_wdata_i = r.data;
    end
  endtask

  // Bus activity that must never be queued.
  task automatic drv_noise(input int core, input bit en);
    st_t r;
    int  k;
    r = {$urandom, 4'($urandom), $urandom};
    k = en ? $urandom_range(0, 3) : 0;
    case (k)
      0:       drv(core, 1'b0, 1'b0, 1'b1, r);
      1:       drv(core, 1'b1, 1'b1, 1'b0, r);
      2:       drv(core, 1'b1, 1'b0, 1'b1, r);
      default: drv(core, 1'b0, 1'b1, 1'b1, r);
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input bit p1, input st_t a,
                       input bit p2, input st_t b);
    if (p1) drv(1, 1'b1, 1'b1, 1'b1, a);
    else    drv_noise(1, 1'b0);
    if (p2) drv(2, 1'b1, 1'b1, 1'b1, b);
    else    drv_noise(2, 1'b0);
    tick();
    drv_noise(1, 1'b0);
    drv_noise(2, 1'b0);
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 30) begin
      tick();
      k++;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_state"}, 64'(bus.state_o), 64'd0);
    chk({tag, "_cmp"}, 64'(bus.compare_cnt_o), 64'd0);
    chk({tag, "_mmcnt"}, 64'(bus.mismatch_cnt_o), 64'd0);
    chk({tag, "_mm"}, 64'(bus.mismatch_o), 64'd0);
    chk({tag, "_ovf"}, 64'(bus.overflow_o), 64'd0);
    chk({tag, "_irq"}, 64'(bus.fault_irq_o), 64'd0);
    chk({tag, "_mmaddr"}, 64'(bus.mm_addr_o), 64'd0);
  endtask

  task automatic do_clear();
    bus.clear_i = 1'b1;
    tick();
    bus.clear_i = 1'b0;
    chk_zero("clear");
    exp_q.delete();
    tick();
    chk("clear_reenter", 64'(bus.state_o), 64'd1);
  endtask

  task automatic run_scn(input bit noise);
    int i1, i2, last;
    for (int k = 0; k < n; k++) push_exp(s1[k], s2[k]);
    i1 = 0;
    i2 = 0;
    last = (t1[n-1] > t2[n-1]) ? t1[n-1] : t2[n-1];
    for (int c = 0; c <= last; c++) begin
      if (i1 < n && t1[i1] == c) begin
        drv(1, 1'b1, 1'b1, 1'b1, s1[i1]);
        i1++;
      end else drv_noise(1, noise);
      if (i2 < n && t2[i2] == c) begin
        drv(2, 1'b1, 1'b1, 1'b1, s2[i2]);
        i2++;
      end else drv_noise(2, noise);
      tick();
    end
    drv_noise(1, 1'b0);
    drv_noise(2, 1'b0);
    wait_drain();
  endtask

  // Monitor: every compare step consumes one expected pair.
  logic [31:0] prev_cmp = '0;
  logic [15:0] prev_mm  = '0;
  logic        prev_mis = 1'b0;
  exp_t        mon_e;

  always @(negedge clk) begin
    if (bus.fault_irq_o === 1'b1) irq_cnt++;
    if (bus.compare_cnt_o == prev_cmp + 32'd1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_compare: count %0d, none queued",
                 bus.compare_cnt_o);
      end else begin
        mon_e = exp_q.pop_front();
        chk("mm_step", 64'(bus.mismatch_cnt_o - prev_mm),
            64'(mon_e.mm));
        if (mon_e.mm && !prev_mis)
          chk("mm_addr", 64'(bus.mm_addr_o), 64'(mon_e.addr));
      end
    end else if (bus.compare_cnt_o != prev_cmp
                 && bus.compare_cnt_o != 32'd0) begin
      chk("cmp_step", 64'(bus.compare_cnt_o),
          64'(prev_cmp + 32'd1));
    end
    prev_cmp = bus.compare_cnt_o;
    prev_mm  = bus.mismatch_cnt_o;
    prev_mis = bus.mismatch_o;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    st_t         a, b;
    int          irq_b;
    logic [31:0] cmp_b;
    bit          corrupt;

    bus.enable_i = 1'b0;
    bus.clear_i  = 1'b0;
    drv_noise(1, 1'b0);
    drv_noise(2, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;
    bus.enable_i = 1'b1;
    tick();
    chk("idle_to_check", 64'(bus.state_o), 64'd1);

    // Identical store on both cores in the same cycle.
    a = {32'h100, 4'hF, 32'hDEADBEEF};
    push_exp(a, a);
    store(1'b1, a, 1'b1, a);
    tick();
    chk("t1_cnt_early", 64'(bus.compare_cnt_o), 64'd0);
    tick();
    chk("t1_cnt", 64'(bus.compare_cnt_o), 64'd1);
    chk("t1_mm", 64'(bus.mismatch_o), 64'd0);
    chk("t1_state", 64'(bus.state_o), 64'd1);

    // Core2 lags core1 by three cycles.
    n = 3;
    for (int k = 0; k < 3; k++) begin
      s1[k] = {32'h2000 + 32'(4*k), 4'hF, $urandom};
      s2[k] = s1[k];
      t1[k] = k;
      t2[k] = k + 3;
    end
    cmp_b = bus.compare_cnt_o;
    run_scn(1'b0);
    chk("t2_cmps", 64'(bus.compare_cnt_o - cmp_b), 64'd3);
    chk("t2_mm", 64'(bus.mismatch_o), 64'd0);
    chk("t2_state", 64'(bus.state_o), 64'd1);

    // Data mismatch raises the fault.
    irq_b = irq_cnt;
    b = a;
    b.data = 32'hDEADBEEE;
    push_exp(a, b);
    store(1'b1, a, 1'b1, b);
    tick();
    chk("t3_mm_early", 64'(bus.mismatch_o), 64'd0);
    tick();
    chk("t3_mm", 64'(bus.mismatch_o), 64'd1);
    chk("t3_addr", 64'(bus.mm_addr_o), 64'h100);
    chk("t3_state", 64'(bus.state_o), 64'd2);
    chk("t3_irq", 64'(bus.fault_irq_o), 64'd1);
    tick();
    chk("t3_irq_off", 64'(bus.fault_irq_o), 64'd0);
    chk("t3_irq_pulses", 64'(irq_cnt - irq_b), 64'd1);
    do_clear();

    // Differences confined to disabled byte lanes are ignored.
    a = {32'h40, 4'b0001, 32'h000000AA};
    b = {32'h40, 4'b0001, 32'hFFFFFFAA};
    push_exp(a, b);
    store(1'b1, a, 1'b1, b);
    tick();
    tick();
    chk("t4_cnt", 64'(bus.compare_cnt_o), 64'd1);
    chk("t4_mm", 64'(bus.mismatch_o), 64'd0);

    // Five stores from core1 only overflow a 4-deep FIFO.
    do_clear();
    irq_b = irq_cnt;
    for (int k = 0; k < 5; k++) begin
      a = {32'h300 + 32'(4*k), 4'hF, $urandom};
      store(1'b1, a, 1'b0, a);
      if (k == 3) begin
        chk("t5_ovf_early", 64'(bus.overflow_o), 64'd0);
        chk("t5_state_early", 64'(bus.state_o), 64'd1);
      end
    end
    chk("t5_ovf", 64'(bus.overflow_o), 64'd1);
    chk("t5_state", 64'(bus.state_o), 64'd2);
    chk("t5_irq", 64'(bus.fault_irq_o), 64'd1);
    tick();
    chk("t5_irq_pulses", 64'(irq_cnt - irq_b), 64'd1);
    do_clear();

    // Asynchronous reset with entries queued.
    a = {32'h500, 4'hF, 32'h11111111};
    store(1'b1, a, 1'b0, a);
    a = {32'h504, 4'hF, 32'h22222222};
    store(1'b1, a, 1'b0, a);
    #2;
    rst = 1'b1;
    #1;
    chk_zero("t6_rst");
    bus.enable_i = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    irq_b = irq_cnt;
    tick();
    chk("t6_idle", 64'(bus.state_o), 64'd0);
    bus.enable_i = 1'b1;
    tick();
    chk("t6_check", 64'(bus.state_o), 64'd1);
    a = {32'h200, 4'hF, $urandom};
    push_exp(a, a);
    store(1'b1, a, 1'b1, a);
    tick();
    tick();
    chk("t6_cnt", 64'(bus.compare_cnt_o), 64'd1);
    chk("t6_mm", 64'(bus.mismatch_o), 64'd0);
    chk("t6_no_irq", 64'(irq_cnt - irq_b), 64'd0);
    do_clear();

    // Randomized skewed schedules, optional divergent last store.
    for (int it = 0; it < 25; it++) begin
      n = $urandom_range(1, 4);
      corrupt = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < n; k++) begin
        s1[k] = {32'h1000 + 32'(4*$urandom_range(0, 63)),
                 4'($urandom), $urandom};
        s2[k] = s1[k];
        for (int bb = 0; bb < 4; bb++) begin
          if (!s1[k].be[bb])
            s2[k].data[8*bb +: 8] = 8'($urandom);
        end
      end
      if (corrupt) begin
        if ($urandom_range(0, 1) == 0)
          s2[n-1].addr = s2[n-1].addr ^ 32'h4;
        else
          s2[n-1].be = s2[n-1].be ^ (4'b0001 << $urandom_range(0, 3));
      end
      t1[0] = $urandom_range(0, 3);
      t2[0] = $urandom_range(0, 3);
      for (int k = 1; k < n; k++) begin
        t1[k] = t1[k-1] + 1 + $urandom_range(0, 2);
        t2[k] = t2[k-1] + 1 + $urandom_range(0, 2);
      end
      cmp_b = bus.compare_cnt_o;
      irq_b = irq_cnt;
      run_scn(1'b1);
      chk("rnd_cmps", 64'(bus.compare_cnt_o - cmp_b), 64'(n));
      chk("rnd_state", 64'(bus.state_o), corrupt ? 64'd2 : 64'd1);
      chk("rnd_mm", 64'(bus.mismatch_o), 64'(corrupt));
      chk("rnd_irq", 64'(irq_cnt - irq_b), 64'(corrupt));
      do_clear();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
